dmem_access_ctrl: RTL

Sequencer between the core's load/store unit and the word-only data memory. The data memory has a combinational word read, a synchronous word write and word indexing by addr[31:2].
- Adds byte and halfword access using lane selection and sign/zero extension.
- Performs read-modify-write for sub-word stores.
- Detects misaligned accesses.
- Exposes a valid/ready request port and a single-cycle response pulse.

---
 rtl/dmem_access_ctrl_pkg.sv | 32 +++
 rtl/dmem_lane_unit.sv | 37 +++
 rtl/dmem_access_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/dmem_access_ctrl_pkg.sv
// Shared encodings for the data-memory access controller: request sizes,
// controller states and the alignment rule.
package dmem_access_ctrl_pkg;

    localparam int unsigned LANE_W = 32;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD   = 3'd1,
        S_STORE  = 3'd2,
        S_RMW_RD = 3'd3,
        S_RMW_WR = 3'd4,
        S_ERR    = 3'd5
    } state_e;

    // Size 2'b11 is illegal and is reported through the same error path.
    function automatic logic is_aligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic ok;
        case (size)
            SZ_BYTE: ok = 1'b1;
            SZ_HALF: ok = ~addr_lo[0];
            SZ_WORD: ok = (addr_lo == 2'b00);
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Little-endian lane logic: load extract/extend and sub-word store merge.
module dmem_lane_unit
    import dmem_access_ctrl_pkg::*;
(
    input  logic [1:0]        addr_lo,
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [LANE_W-1:0] rd_word,
    input  logic [LANE_W-1:0] wdata,
    output logic [LANE_W-1:0] ld_data_c,
    output logic [LANE_W-1:0] st_word_c
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = rd_word[{addr_lo, 3'b000} +: 8];
        half_v = addr_lo[1] ? rd_word[31:16] : rd_word[15:0];
        case (size)
            SZ_BYTE: ld_data_c = {{24{~is_unsigned & byte_v[7]}}, byte_v};
            SZ_HALF: ld_data_c = {{16{~is_unsigned & half_v[15]}}, half_v};
            default: ld_data_c = rd_word;
        endcase
    end

    // Old word keeps every lane that the store does not touch.
    always_comb begin
        st_word_c = rd_word;
        case (size)
            SZ_BYTE: st_word_c[{addr_lo, 3'b000} +: 8]        = wdata[7:0];
            SZ_HALF: st_word_c[{addr_lo[1], 4'b0000} +: 16]   = wdata[15:0];
            default: st_word_c = wdata;
        endcase
    end

endmodule

// File: rtl/dmem_access_ctrl.sv
// Load/store sequencer in front of a word-only data memory: sub-word access,
// read-modify-write stores, misalignment errors and a one-cycle response pulse.
module dmem_access_ctrl
    import dmem_access_ctrl_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [DATA_W-1:0] resp_rdata,
    output logic              mem_read,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    state_e            state_q, state_d;
    logic [1:0]        addr_lo_q, addr_lo_d;
    logic [1:0]        size_q, size_d;
    logic              we_q, we_d;
    logic              uns_q, uns_d;
    logic [DATA_W-1:0] wdata_q, wdata_d;

    logic              req_ready_q, req_ready_d;
    logic              resp_valid_q, resp_valid_d;
    logic              resp_err_q, resp_err_d;
    logic [DATA_W-1:0] resp_rdata_q, resp_rdata_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic [DATA_W-1:0] ld_data_c;
    logic [DATA_W-1:0] st_word_c;

    dmem_lane_unit u_lane (
        .addr_lo     (addr_lo_q),
        .size        (size_q),
        .is_unsigned (uns_q),
        .rd_word     (mem_rdata),
        .wdata       (wdata_q),
        .ld_data_c   (ld_data_c),
        .st_word_c   (st_word_c)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            addr_lo_q    <= '0;
            size_q       <= '0;
            we_q         <= 1'b0;
            uns_q        <= 1'b0;
            wdata_q      <= '0;
            req_ready_q  <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
            resp_rdata_q <= '0;
            mem_read_q   <= 1'b0;
            mem_write_q  <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
        end else begin
            state_q      <= state_d;
            addr_lo_q    <= addr_lo_d;
            size_q       <= size_d;
            we_q         <= we_d;
            uns_q        <= uns_d;
            wdata_q      <= wdata_d;
            req_ready_q  <= req_ready_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
            resp_rdata_q <= resp_rdata_d;
            mem_read_q   <= mem_read_d;
            mem_write_q  <= mem_write_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
        end
    end

    // Strobes and responses are computed one state ahead so they leave flops.
    always_comb begin
        state_d      = state_q;
        addr_lo_d    = addr_lo_q;
        size_d       = size_q;
        we_d         = we_q;
        uns_d        = uns_q;
        wdata_d      = wdata_q;
        resp_valid_d = 1'b0;
        resp_err_d   = 1'b0;
        resp_rdata_d = resp_rdata_q;
        mem_read_d   = 1'b0;
        mem_write_d  = 1'b0;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (req_valid && req_ready_q) begin
                    addr_lo_d = req_addr[1:0];
                    size_d    = req_size;
                    we_d      = req_we;
                    uns_d     = req_unsigned;
                    wdata_d   = req_wdata;
                    if (!is_aligned(req_size, req_addr[1:0])) begin
                        state_d = S_ERR;
                    end else begin
                        mem_addr_d = {req_addr[ADDR_W-1:2], 2'b00};
                        if (!req_we) begin
                            state_d    = S_LOAD;
                            mem_read_d = 1'b1;
                        end else if (req_size == SZ_WORD) begin
                            state_d     = S_STORE;
                            mem_write_d = 1'b1;
                            mem_wdata_d = req_wdata;
                        end else begin
                            state_d    = S_RMW_RD;
                            mem_read_d = 1'b1;
                        end
                    end
                end
            end
            S_RMW_RD: begin
                state_d     = S_RMW_WR;
                mem_write_d = 1'b1;
                mem_wdata_d = st_word_c;
            end
            S_LOAD, S_STORE, S_RMW_WR: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_rdata_d = we_q ? '0 : ld_data_c;
            end
            S_ERR: begin
                state_d      = S_IDLE;
                resp_valid_d = 1'b1;
                resp_err_d   = 1'b1;
                resp_rdata_d = '0;
            end
            default: state_d = S_IDLE;
        endcase

        req_ready_d = (state_d == S_IDLE);
    end

    assign req_ready  = req_ready_q;
    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_rdata = resp_rdata_q;
    assign mem_read   = mem_read_q;
    assign mem_write  = mem_write_q;
    assign mem_addr   = mem_addr_q;
    assign mem_wdata  = mem_wdata_q;

endmodule
